// File: rtl/tile_scheduler_if.sv
// Host command, array control and X/Y buffer signals of tile_scheduler.
// cycle_count exists only when TILE_SCHED_PERF_EN is defined.
interface tile_scheduler_if #(
  parameter int unsigned TILE_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [TILE_W-1:0] cmd_num_tiles;
  logic [ADDR_W-1:0] cmd_x_base;
  logic [ADDR_W-1:0] cmd_y_base;
  logic              array_start;
  logic              array_clr;
  logic              array_done;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_addr;
  logic              y_wr_en;
  logic [ADDR_W-1:0] y_addr;
  logic              busy;
  logic              job_done;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]       cycle_count;
`endif

  modport master (
    input  cmd_valid, cmd_num_tiles, cmd_x_base, cmd_y_base, array_done,
    output cmd_ready, array_start, array_clr, x_rd_en, x_addr,
           y_wr_en, y_addr, busy, job_done
`ifdef TILE_SCHED_PERF_EN
    , output cycle_count
`endif
  );

  modport slave (
    output cmd_valid, cmd_num_tiles, cmd_x_base, cmd_y_base, array_done,
    input  cmd_ready, array_start, array_clr, x_rd_en, x_addr,
           y_wr_en, y_addr, busy, job_done
`ifdef TILE_SCHED_PERF_EN
    , input cycle_count
`endif
  );
endinterface

// File: rtl/tile_scheduler.sv
// Job-level sequencer: runs N tiles through the systolic array (start, X reads,
// wait done, Y drain, clear). Optional busy-cycle counter under TILE_SCHED_PERF_EN.
module tile_scheduler #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 4,
  parameter int unsigned TILE_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  tile_scheduler_if.master   io
);

  localparam int unsigned CNT_MAX = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RUN, S_DRAIN, S_CLEAR, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ADDR_W-1:0] xbase_q, xbase_d;
  logic [ADDR_W-1:0] ybase_q, ybase_d;
  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic [ADDR_W-1:0] y_addr_q, y_addr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              clr_q, clr_d;
  logic              x_rd_en_q, x_rd_en_d;
  logic              y_wr_en_q, y_wr_en_d;
  logic              job_done_q, job_done_d;
  logic              accept_c;

  assign accept_c = cmd_ready_q && io.cmd_valid;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      tile_q      <= '0;
      xbase_q     <= '0;
      ybase_q     <= '0;
      x_addr_q    <= '0;
      y_addr_q    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      clr_q       <= 1'b0;
      x_rd_en_q   <= 1'b0;
      y_wr_en_q   <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      tile_q      <= tile_d;
      xbase_q     <= xbase_d;
      ybase_q     <= ybase_d;
      x_addr_q    <= x_addr_d;
      y_addr_q    <= y_addr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      clr_q       <= clr_d;
      x_rd_en_q   <= x_rd_en_d;
      y_wr_en_q   <= y_wr_en_d;
      job_done_q  <= job_done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    tile_d   = tile_q;
    xbase_d  = xbase_q;
    ybase_d  = ybase_q;
    x_addr_d = x_addr_q;
    y_addr_d = y_addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          num_d   = io.cmd_num_tiles;
          xbase_d = io.cmd_x_base;
          ybase_d = io.cmd_y_base;
          tile_d  = '0;
          state_d = (io.cmd_num_tiles == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (io.array_done) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (cnt_q < CNT_W'(ROWS)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(COLS - 1)) begin
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CLEAR: begin
        xbase_d = xbase_q + ADDR_W'(ROWS);
        ybase_d = ybase_q + ADDR_W'(COLS);
        tile_d  = tile_q + TILE_W'(1);
        state_d = (tile_q == num_q - TILE_W'(1)) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    start_d     = (state_d == S_ISSUE);
    clr_d       = (state_d == S_CLEAR);
    job_done_d  = (state_d == S_FINISH);
    x_rd_en_d   = (state_d == S_RUN) && (cnt_d < CNT_W'(ROWS));
    y_wr_en_d   = (state_d == S_DRAIN);
    if (x_rd_en_d) x_addr_d = xbase_d + ADDR_W'(cnt_d);
    if (y_wr_en_d) y_addr_d = ybase_d + ADDR_W'(cnt_d);
  end

  assign io.cmd_ready   = cmd_ready_q;
  assign io.busy        = busy_q;
  assign io.array_start = start_q;
  assign io.array_clr   = clr_q;
  assign io.x_rd_en     = x_rd_en_q;
  assign io.x_addr      = x_addr_q;
  assign io.y_wr_en     = y_wr_en_q;
  assign io.y_addr      = y_addr_q;
  assign io.job_done    = job_done_q;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] cyc_q;

  // Busy-cycle counter, saturating, restarted by each accepted job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (accept_c) begin
      cyc_q <= '0;
    end else if (busy_q && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign io.cycle_count = cyc_q;
`endif

endmodule
